// File: rtl/deteccion_riesgos.sv
// Hazard detection unit for the pipelined core.
// Freezes the whole pipeline while a data-memory access is outstanding (with a
// bounded wait), flushes on taken branches and inserts a bubble on load-use
// hazards. Also keeps a saturating stall-cycle counter and a sticky timeout flag.
module deteccion_riesgos #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       Ra_F_Reg,
    input  logic             RE_A_F_Reg,
    input  logic [3:0]       Rb_F_Reg,
    input  logic             RE_B_F_Reg,
    input  logic [3:0]       Robj_Reg_Exe,
    input  logic             WE_Reg_Exe,
    input  logic             mem_RE_Reg_Exe,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             branch_taken,
    input  logic             clr_stats,
    output logic             stall_PC,
    output logic             stall_F_Reg,
    output logic             stall_Reg_Exe,
    output logic             stall_Exe_Mem,
    output logic             bubble_Reg_Exe,
    output logic             bubble_Mem_WB,
    output logic             flush_F_Reg,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_error
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0]       WCNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q, state_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             mem_error_q, mem_error_d;

    logic timeout;
    logic freeze;
    logic load_use;

    // Memory-wait timeout, pipeline freeze and load-use hazard conditions.
    always_comb begin
        timeout  = (state_q == MEM_WAIT) && (wcnt_q == WCNT_LAST);
        freeze   = ((state_q == RUN) && mem_req && !mem_ack) ||
                   ((state_q == MEM_WAIT) && !mem_ack && !timeout);
        load_use = WE_Reg_Exe && mem_RE_Reg_Exe &&
                   ((RE_A_F_Reg && (Ra_F_Reg == Robj_Reg_Exe)) ||
                    (RE_B_F_Reg && (Rb_F_Reg == Robj_Reg_Exe)));
    end

    // Control outputs: freeze beats branch beats load-use; all low while in reset.
    always_comb begin
        stall_PC       = 1'b0;
        stall_F_Reg    = 1'b0;
        stall_Reg_Exe  = 1'b0;
        stall_Exe_Mem  = 1'b0;
        bubble_Reg_Exe = 1'b0;
        bubble_Mem_WB  = 1'b0;
        flush_F_Reg    = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                stall_PC      = 1'b1;
                stall_F_Reg   = 1'b1;
                stall_Reg_Exe = 1'b1;
                stall_Exe_Mem = 1'b1;
                bubble_Mem_WB = 1'b1;
            end else if (branch_taken) begin
                flush_F_Reg    = 1'b1;
                bubble_Reg_Exe = 1'b1;
            end else if (load_use) begin
                stall_PC       = 1'b1;
                stall_F_Reg    = 1'b1;
                bubble_Reg_Exe = 1'b1;
            end
        end
    end

    // Next state of the memory-wait FSM; mem_ack wins over the timeout.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (mem_ack || timeout) begin
                    state_d = RUN;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Statistics: clear has priority over counting and over flag setting.
    always_comb begin
        stall_count_d = stall_count_q;
        mem_error_d   = mem_error_q;
        if (clr_stats) begin
            stall_count_d = '0;
            mem_error_d   = 1'b0;
        end else begin
            if (stall_PC && (stall_count_q != CNT_MAX)) begin
                stall_count_d = stall_count_q + 1'b1;
            end
            if (timeout && !mem_ack) begin
                mem_error_d = 1'b1;
            end
        end
    end

    // State and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wcnt_q        <= 8'd0;
            stall_count_q <= '0;
            mem_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            stall_count_q <= stall_count_d;
            mem_error_q   <= mem_error_d;
        end
    end

    assign stall_count = stall_count_q;
    assign mem_error   = mem_error_q;

endmodule

// File: tb/tb_deteccion_riesgos.sv
// Self-checking bench for deteccion_riesgos: directed hazard scenarios followed
// by random traffic, checked through an expectation queue.
module tb_deteccion_riesgos;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [3:0]       Ra_F_Reg, Rb_F_Reg, Robj_Reg_Exe;
    logic             RE_A_F_Reg, RE_B_F_Reg, WE_Reg_Exe, mem_RE_Reg_Exe;
    logic             mem_req, mem_ack, branch_taken, clr_stats;
    logic             stall_PC, stall_F_Reg, stall_Reg_Exe, stall_Exe_Mem;
    logic             bubble_Reg_Exe, bubble_Mem_WB, flush_F_Reg;
    logic [CNT_W-1:0] stall_count;
    logic             mem_error;

    deteccion_riesgos #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .Ra_F_Reg(Ra_F_Reg), .RE_A_F_Reg(RE_A_F_Reg),
        .Rb_F_Reg(Rb_F_Reg), .RE_B_F_Reg(RE_B_F_Reg),
        .Robj_Reg_Exe(Robj_Reg_Exe), .WE_Reg_Exe(WE_Reg_Exe),
        .mem_RE_Reg_Exe(mem_RE_Reg_Exe),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .branch_taken(branch_taken), .clr_stats(clr_stats),
        .stall_PC(stall_PC), .stall_F_Reg(stall_F_Reg),
        .stall_Reg_Exe(stall_Reg_Exe), .stall_Exe_Mem(stall_Exe_Mem),
        .bubble_Reg_Exe(bubble_Reg_Exe), .bubble_Mem_WB(bubble_Mem_WB),
        .flush_F_Reg(flush_F_Reg),
        .stall_count(stall_count), .mem_error(mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl = {stall_PC, stall_F_Reg, stall_Reg_Exe, stall_Exe_Mem,
    //         bubble_Reg_Exe, bubble_Mem_WB, flush_F_Reg}
    typedef struct packed {
        logic [6:0]       ctrl;
        logic [CNT_W-1:0] cnt;
        logic             err;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: how many cycles the pending memory access has waited
    // (-1 = no access outstanding), plus the statistics.
    int m_wait = -1;
    int m_cnt  = 0;
    bit m_err  = 1'b0;

    function automatic exp_t model_step(
        input bit rst, input bit haz, input bit req, input bit ack,
        input bit br, input bit clr);
        exp_t e;
        bit   waiting, expired, frz;
        e = '0;
        if (!rst) begin
            m_wait = -1;
            m_cnt  = 0;
            m_err  = 1'b0;
            return e;
        end
        waiting = (m_wait >= 0);
        expired = waiting && (m_wait == TIMEOUT - 1);
        frz     = waiting ? (!ack && !expired) : (req && !ack);
        if (frz)       e.ctrl = 7'b1111010;
        else if (br)   e.ctrl = 7'b0000101;
        else if (haz)  e.ctrl = 7'b1100100;
        e.cnt = CNT_W'(m_cnt);
        e.err = m_err;
        if (clr) begin
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            if (e.ctrl[6] && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (expired && !ack) m_err = 1'b1;
        end
        if (waiting) m_wait = (ack || expired) ? -1 : m_wait + 1;
        else if (req && !ack) m_wait = 0;
        return e;
    endfunction

    task automatic apply(input bit rst,
                         input logic [3:0] ra, input bit rea,
                         input logic [3:0] rb, input bit reb,
                         input logic [3:0] robj, input bit we, input bit mre,
                         input bit req, input bit ack, input bit br, input bit clr);
        bit haz;
        @(negedge clk);
        rst_n = rst;
        Ra_F_Reg = ra;  RE_A_F_Reg = rea;
        Rb_F_Reg = rb;  RE_B_F_Reg = reb;
        Robj_Reg_Exe = robj; WE_Reg_Exe = we; mem_RE_Reg_Exe = mre;
        mem_req = req; mem_ack = ack; branch_taken = br; clr_stats = clr;
        haz = we && mre && ((rea && ra == robj) || (reb && rb == robj));
        #1;
        q.push_back(model_step(rst, haz, req, ack, br, clr));
    endtask

    task automatic idle(input bit rst);
        apply(rst, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle the DUT outputs are compared with the oldest expectation.
    initial begin
        exp_t e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {stall_PC, stall_F_Reg, stall_Reg_Exe, stall_Exe_Mem,
                       bubble_Reg_Exe, bubble_Mem_WB, flush_F_Reg};
                n_tests++;
                if (act !== e.ctrl) begin
                    n_fail++;
                    $display("FAIL ctrl t=%0t got=%b want=%b", $time, act, e.ctrl);
                end
                n_tests++;
                if (stall_count !== e.cnt) begin
                    n_fail++;
                    $display("FAIL stall_count t=%0t got=%0d want=%0d", $time, stall_count, e.cnt);
                end
                n_tests++;
                if (mem_error !== e.err) begin
                    n_fail++;
                    $display("FAIL mem_error t=%0t got=%b want=%b", $time, mem_error, e.err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        Ra_F_Reg = '0; Rb_F_Reg = '0; Robj_Reg_Exe = '0;
        RE_A_F_Reg = 0; RE_B_F_Reg = 0; WE_Reg_Exe = 0; mem_RE_Reg_Exe = 0;
        mem_req = 0; mem_ack = 0; branch_taken = 0; clr_stats = 0;

        // Reset state, with noisy inputs that must not reach the outputs.
        apply(0, 4'd3, 1, 4'd3, 1, 4'd3, 1, 1, 1, 0, 1, 0);
        idle(0);
        idle(1);

        // Load-use on Rb, then the bubble clears the hazard.
        apply(1, 4'd0, 0, 4'd3, 1, 4'd3, 1, 1, 0, 0, 0, 0);
        idle(1);
        // Same registers, non-load producer.
        apply(1, 4'd0, 0, 4'd3, 1, 4'd3, 1, 0, 0, 0, 0, 0);
        // Load-use on Ra.
        apply(1, 4'd7, 1, 4'd1, 0, 4'd7, 1, 1, 0, 0, 0, 0);
        idle(1);

        // Memory wait: three cycles without ack, then ack.
        repeat (3) apply(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 0, 0, 0);
        apply(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 1, 0, 0);
        idle(1);
        // Request acknowledged in the same cycle: no stall.
        apply(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 1, 0, 0);

        // Timeout: ack never comes.
        repeat (5) apply(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 0, 0, 0);
        idle(1);
        idle(1);

        // Branch with load-use hazard: branch wins.
        apply(1, 4'd5, 1, 4'd0, 0, 4'd5, 1, 1, 0, 0, 1, 0);
        // Freeze with branch and hazard: branch ignored.
        apply(1, 4'd5, 1, 4'd0, 0, 4'd5, 1, 1, 1, 0, 1, 0);
        apply(1, 4'd5, 1, 4'd0, 0, 4'd5, 1, 1, 0, 0, 1, 0);
        apply(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 1, 0, 0);

        // Clear together with a hazard.
        apply(1, 4'd2, 1, 4'd0, 0, 4'd2, 1, 1, 0, 0, 0, 1);
        idle(1);

        // Reset in the middle of a wait.
        apply(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 0, 0, 0);
        apply(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 0, 0, 0);
        apply(0, 4'd4, 1, 4'd4, 1, 4'd4, 1, 1, 1, 0, 1, 0);
        idle(1);
        idle(1);

        // Random traffic; small register space so hazards are frequent.
        for (int i = 0; i < 2000; i++) begin
            apply(($urandom_range(0, 99) >= 2),
                  4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 25),
                  ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 3));
        end

        @(negedge clk);
        #3;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain got=%0d want=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
